// File: rtl/flash_detector_if.sv
// flash_detector_if
// Purpose: bundles the flash line and the detector's status outputs so that
//          the detector and its driver share one connection object.
// Signals:
//   in   - flash line, synchronous to the detector clock
//   det  - one-cycle pulse: a complete valid pattern was received
//   err  - one-cycle pulse: a started pattern was abandoned
//   busy - high while a pattern is in progress
// Modports:
//   master - drives in, observes det/err/busy (stimulus side)
//   slave  - samples in, drives det/err/busy (detector side)
interface flash_detector_if;
  logic in;
  logic det;
  logic err;
  logic busy;

  modport master (output in, input det, input err, input busy);
  modport slave  (input in, output det, output err, output busy);
endinterface

// File: rtl/flash_detector.sv
// flash_detector
// Purpose: recognises the flash pattern high/low/high/low/high/low, where
//          every high pulse lasts T_ON +/- TOL cycles and every low gap lasts
//          T_OFF +/- TOL cycles.
//          - det pulses for one cycle after the first low sample that ends
//            the third pulse.
//          - err pulses for one cycle when a started pattern breaks, either
//            through a level that is too short or one that is too long.
// Ports:
//   clk - single clock; all state changes on its rising edge
//   rst - synchronous, active-high reset
//   bus - flash_detector_if.slave: in (flash line), det, err, busy
//         (all outputs registered)
// Parameters:
//   T_ON, T_OFF - nominal pulse and gap lengths in cycles
//   TOL         - allowed deviation on each length
//   CW          - width of the length counter
//   Legal settings satisfy:
//     TOL < T_ON, TOL < T_OFF, T_ON+TOL < 2**CW, T_OFF+TOL < 2**CW
module flash_detector #(
  parameter int T_ON  = 4,
  parameter int T_OFF = 4,
  parameter int TOL   = 1,
  parameter int CW    = 8
) (
  input  logic              clk,
  input  logic              rst,
  flash_detector_if.slave   bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] H1   = 3'd1;
  localparam logic [2:0] L1   = 3'd2;
  localparam logic [2:0] H2   = 3'd3;
  localparam logic [2:0] L2   = 3'd4;
  localparam logic [2:0] H3   = 3'd5;

  localparam logic [CW-1:0] ON_MIN  = CW'(T_ON - TOL);
  localparam logic [CW-1:0] ON_MAX  = CW'(T_ON + TOL);
  localparam logic [CW-1:0] OFF_MIN = CW'(T_OFF - TOL);
  localparam logic [CW-1:0] OFF_MAX = CW'(T_OFF + TOL);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  logic [2:0]    state_r;
  logic [2:0]    state_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic          prev_r;
  logic          det_r;
  logic          err_r;
  logic          busy_r;
  logic          det_s;
  logic          err_s;
  logic          exp_lvl_s;
  logic [CW-1:0] len_min_s;
  logic [CW-1:0] len_max_s;

  // Level state that follows a correctly terminated level.
  // H3 has no successor: it terminates in IDLE with det.
  function automatic logic [2:0] succ_state(input logic [2:0] st);
    case (st)
      H1:      succ_state = L1;
      L1:      succ_state = H2;
      H2:      succ_state = L2;
      L2:      succ_state = H3;
      default: succ_state = IDLE;
    endcase
  endfunction

  // Expected line level and the legal length window for the current state.
  always_comb begin
    exp_lvl_s = 1'b0;
    len_min_s = ON_MIN;
    len_max_s = ON_MAX;
    case (state_r)
      H1, H2, H3: begin
        exp_lvl_s = 1'b1;
        len_min_s = ON_MIN;
        len_max_s = ON_MAX;
      end
      L1, L2: begin
        exp_lvl_s = 1'b0;
        len_min_s = OFF_MIN;
        len_max_s = OFF_MAX;
      end
      default: begin
        exp_lvl_s = 1'b0;
        len_min_s = ON_MIN;
        len_max_s = ON_MAX;
      end
    endcase
  end

  // Next-state, counter and pulse decisions.
  // The sample that changes the level is counted as the first cycle of the
  // next level, so each advance reloads the counter with one.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    det_s   = 1'b0;
    err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        // A start needs a genuine rising edge. prev resets to 1, so a line
        // that is already high when reset is released never starts a pattern.
        if (bus.in && !prev_r) begin
          state_s = H1;
          cnt_s   = CNT_ONE;
        end else begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
        end
      end
      H1, L1, H2, L2, H3: begin
        if (bus.in == exp_lvl_s) begin
          // The counter saturates at len_max: one more sample at the same
          // level is an overrun, so the counter can never wrap.
          if (cnt_r < len_max_s) begin
            cnt_s = cnt_r + CNT_ONE;
          end else begin
            err_s   = 1'b1;
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
          end
        end else begin
          if (cnt_r >= len_min_s) begin
            if (state_r == H3) begin
              det_s   = 1'b1;
              state_s = IDLE;
              cnt_s   = CNT_ZERO;
            end else begin
              state_s = succ_state(state_r);
              cnt_s   = CNT_ONE;
            end
          end else begin
            err_s   = 1'b1;
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
          end
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter, previous sample and registered outputs.
  // Reset has priority over every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      prev_r  <= 1'b1;
      det_r   <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      prev_r  <= bus.in;
      det_r   <= det_s;
      err_r   <= err_s;
      busy_r  <= (state_s != IDLE);
    end
  end

  assign bus.det  = det_r;
  assign bus.err  = err_r;
  assign bus.busy = busy_r;

endmodule
